instr_fetch: RTL and testbench

//   Instruction fetch stage of the CPE CPU. Generates the fetch PC, issues
//   in-order read requests to instruction memory, buffers the returned words,
//   and presents instr/opcode/PC to decode. opcode_w_o drives the control

---
 rtl/instr_fetch.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues in-order imem reads under a credit limit,
// buffers the returned words and presents them, with their PCs, to decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter int          MAX_OUTST = 2
) (
    input  logic        clk_w_i,
    input  logic        rst_w_i_l,
    output logic        imem_req_w_o_h,
    output logic [31:0] imem_addr_w_o,
    input  logic        imem_gnt_w_i_h,
    input  logic        imem_rvalid_w_i_h,
    input  logic [31:0] imem_rdata_w_i,
    input  logic        redirect_w_i_h,
    input  logic [31:0] redirect_pc_w_i,
    input  logic        stall_w_i_h,
    output logic        instr_valid_w_o_h,
    output logic [31:0] instr_w_o,
    output logic [6:0]  opcode_w_o,
    output logic [31:0] instr_pc_w_o
);
    localparam int          PW  = $clog2(BUF_DEPTH);
    localparam int          CW  = $clog2(BUF_DEPTH + 1);
    localparam int          OW  = $clog2(MAX_OUTST + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   buf_data_q [BUF_DEPTH];
    logic [31:0]   buf_data_d [BUF_DEPTH];
    logic [31:0]   buf_pc_q   [BUF_DEPTH];
    logic [31:0]   buf_pc_d   [BUF_DEPTH];

    logic credit_ok;
    logic accept;
    logic consume;
    logic keep_word;

    always_ff @(posedge clk_w_i) begin
        if (!rst_w_i_l) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN simply means stale responses from before a redirect are still due.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = RUN;
            RUN, DRAIN: state_d = (discard_d != '0) ? DRAIN : RUN;
            default:    state_d = IDLE;
        endcase
    end

    // Outstanding plus buffered never exceeds the buffer, so every kept word has a slot.
    always_comb begin
        credit_ok      = (int'(outst_q) + int'(count_q) < BUF_DEPTH) &&
                         (int'(outst_q) < MAX_OUTST);
        imem_req_w_o_h = (state_q != IDLE) && credit_ok && !redirect_w_i_h;
    end

    always_comb begin
        accept     = imem_req_w_o_h & imem_gnt_w_i_h;
        consume    = instr_valid_w_o_h & !stall_w_i_h;
        keep_word  = imem_rvalid_w_i_h & (discard_q == '0) & !redirect_w_i_h;

        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        buf_data_d = buf_data_q;
        buf_pc_d   = buf_pc_q;

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        case ({accept, imem_rvalid_w_i_h})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        if (imem_rvalid_w_i_h && discard_q != '0) begin
            discard_d = discard_q - OW'(1);
        end

        if (keep_word) begin
            buf_data_d[wr_ptr_q] = imem_rdata_w_i;
            buf_pc_d[wr_ptr_q]   = resp_pc_q;
            wr_ptr_d             = wr_ptr_q + PW'(1);
            resp_pc_d            = resp_pc_q + 32'd4;
        end

        if (consume) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({keep_word, consume})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Redirect wins over everything; whatever is still in flight becomes stale.
        if (redirect_w_i_h) begin
            fetch_pc_d = redirect_pc_w_i & ~32'd3;
            resp_pc_d  = redirect_pc_w_i & ~32'd3;
            discard_d  = outst_d;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk_w_i) begin
        if (!rst_w_i_l) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            buf_data_q <= buf_data_d;
            buf_pc_q   <= buf_pc_d;
        end
    end

    assign imem_addr_w_o     = fetch_pc_q;
    assign instr_valid_w_o_h = (count_q != '0);
    assign instr_w_o         = instr_valid_w_o_h ? buf_data_q[rd_ptr_q] : NOP;
    assign opcode_w_o        = instr_w_o[6:0];
    assign instr_pc_w_o      = instr_valid_w_o_h ? buf_pc_q[rd_ptr_q] : 32'h0;

    // A kept response arriving into a full, non-draining buffer means imem broke the credit contract.
    assert property (@(posedge clk_w_i) disable iff (!rst_w_i_l)
        !(imem_rvalid_w_i_h && !redirect_w_i_h && discard_q == '0 &&
          int'(count_q) == BUF_DEPTH && !consume));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: an imem model plus a program-order PC reference,
// directed scenarios pinned by literal expectations, then a long random run.
module tb_instr_fetch;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] MAIN_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst_l;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] pc;

    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [31:0] w_pc;

    instr_fetch u_dut (
        .clk_w_i           (clk),
        .rst_w_i_l         (rst_l),
        .imem_req_w_o_h    (req),
        .imem_addr_w_o     (addr),
        .imem_gnt_w_i_h    (gnt),
        .imem_rvalid_w_i_h (rvalid),
        .imem_rdata_w_i    (rdata),
        .redirect_w_i_h    (redirect),
        .redirect_pc_w_i   (redirect_pc),
        .stall_w_i_h       (stall),
        .instr_valid_w_o_h (valid),
        .instr_w_o         (instr),
        .opcode_w_o        (opcode),
        .instr_pc_w_o      (pc)
    );

    instr_fetch #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk_w_i           (clk),
        .rst_w_i_l         (rst_l),
        .imem_req_w_o_h    (w_req),
        .imem_addr_w_o     (w_addr),
        .imem_gnt_w_i_h    (1'b1),
        .imem_rvalid_w_i_h (w_rvalid),
        .imem_rdata_w_i    (w_rdata),
        .redirect_w_i_h    (1'b0),
        .redirect_pc_w_i   (32'h0),
        .stall_w_i_h       (1'b0),
        .instr_valid_w_o_h (w_valid),
        .instr_w_o         (w_instr),
        .opcode_w_o        (w_opcode),
        .instr_pc_w_o      (w_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          compared;
    int          mismatched;
    int          cyc;
    logic        model_ready;
    logic        after_reset;
    logic        exp_flush;
    logic        hold_req;
    logic [31:0] hold_addr;
    logic [31:0] exp_req_pc;
    logic [31:0] exp_pc;
    logic [31:0] w_exp_pc;
    int          first_req_cyc;
    int          first_valid_cyc;
    int          req_after_redir;
    logic [6:0]  first_opcode;
    logic [31:0] pend_q[$];
    logic [31:0] w_pend[$];
    logic [31:0] grant_log[$];
    logic [31:0] deliver_log[$];
    logic [31:0] w_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F33;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Outputs at the falling edge reflect the state after the previous rising edge.
    task automatic checkOutput();
        logic [31:0] w;
        if (!model_ready) return;
        if (after_reset) begin
            checkValue("reset_req", 32'(req), 32'(0));
            checkValue("reset_addr", addr, MAIN_PC);
            checkValue("reset_instr", instr, NOP);
            checkValue("reset_wrap_addr", w_addr, WRAP_PC);
        end
        if (exp_flush) checkValue("flush_valid", 32'(valid), 32'(0));
        if (valid) begin
            w = mem_word(exp_pc);
            checkValue("pc_order", pc, exp_pc);
            checkValue("instr_data", instr, w);
            checkValue("opcode", 32'(opcode), 32'(w[6:0]));
            if (first_valid_cyc < 0) begin
                first_valid_cyc = cyc;
                first_opcode    = opcode;
            end
        end else begin
            checkValue("idle_instr", instr, NOP);
            checkValue("idle_pc", pc, 32'h0);
        end
        if (w_valid) begin
            w = mem_word(w_exp_pc);
            checkValue("wrap_pc", w_pc, w_exp_pc);
            checkValue("wrap_instr", w_instr, w);
            w_log.push_back(w_pc);
        end
    endtask

    // One clock cycle: check, drive inputs, check request rules, advance the model.
    task automatic applyStimulus(input logic rst_n, input logic st, input logic rd,
                                 input logic [31:0] rpc, input int gnt_pct, input int rv_pct);
        logic accepted;
        logic consumed;
        checkOutput();
        rst_l       = rst_n;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        gnt         = (int'($urandom_range(99)) < gnt_pct);
        rvalid      = (pend_q.size() > 0) && (int'($urandom_range(99)) < rv_pct);
        rdata       = 32'hDEAD_BEEF;
        if (rvalid) rdata = mem_word(pend_q[0]);
        w_rvalid    = (w_pend.size() > 0);
        w_rdata     = 32'hDEAD_BEEF;
        if (w_rvalid) w_rdata = mem_word(w_pend[0]);
        #1;
        if (rst_n && model_ready) begin
            if (hold_req && !rd) begin
                checkValue("req_hold", 32'(req), 32'(1));
                checkValue("addr_hold", addr, hold_addr);
            end
            if (rd) checkValue("req_on_redirect", 32'(req), 32'(0));
            if (req) checkValue("req_addr", addr, exp_req_pc);
        end
        accepted = req && gnt;
        consumed = valid && !st && !rd;
        if (!rst_n) begin
            pend_q.delete();
            w_pend.delete();
            exp_req_pc      = MAIN_PC;
            exp_pc          = MAIN_PC;
            w_exp_pc        = WRAP_PC;
            exp_flush       = 1'b1;
            after_reset     = 1'b1;
            hold_req        = 1'b0;
            model_ready     = 1'b1;
            first_req_cyc   = -1;
            first_valid_cyc = -1;
        end else begin
            after_reset = 1'b0;
            exp_flush   = 1'b0;
            if (req && first_req_cyc < 0) first_req_cyc = cyc;
            if (req && req_after_redir < 0) req_after_redir = cyc;
            if (rvalid) void'(pend_q.pop_front());
            if (accepted) begin
                pend_q.push_back(exp_req_pc);
                grant_log.push_back(addr);
                exp_req_pc = exp_req_pc + 32'd4;
            end
            hold_req  = req && !gnt;
            hold_addr = addr;
            if (consumed) begin
                deliver_log.push_back(pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (rd) begin
                exp_pc          = rpc & ~32'd3;
                exp_req_pc      = rpc & ~32'd3;
                exp_flush       = 1'b1;
                hold_req        = 1'b0;
                req_after_redir = -1;
            end
            if (w_rvalid) void'(w_pend.pop_front());
            if (w_req) w_pend.push_back(w_addr);
            if (w_valid) w_exp_pc = w_exp_pc + 32'd4;
            checkValue("outst_limit", 32'(pend_q.size() <= 2), 32'(1));
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          gi;
        int          di;
        int          redir_cyc;
        int          start_n;
        logic        found;
        logic        rd;
        logic [31:0] tgt;

        compared = 0; mismatched = 0; cyc = 0;
        model_ready = 1'b0; after_reset = 1'b0; exp_flush = 1'b0; hold_req = 1'b0;
        hold_addr = '0; exp_req_pc = MAIN_PC; exp_pc = MAIN_PC; w_exp_pc = WRAP_PC;
        first_req_cyc = -1; first_valid_cyc = -1; req_after_redir = -1; first_opcode = '0;
        rst_l = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; redirect = 1'b0;
        redirect_pc = '0; stall = 1'b0; w_rvalid = 1'b0; w_rdata = '0;
        @(negedge clk);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0, 0);

        // Zero-wait imem after reset release.
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 100, 100);
        checkValue("grant_count", 32'(grant_log.size() >= 3), 32'(1));
        checkValue("first_addr0", grant_log[0], 32'h0000_0000);
        checkValue("first_addr1", grant_log[1], 32'h0000_0004);
        checkValue("first_addr2", grant_log[2], 32'h0000_0008);
        checkValue("first_latency", 32'(first_valid_cyc - first_req_cyc), 32'(2));
        checkValue("first_opcode", 32'(first_opcode), 32'h33);
        checkValue("first_deliver", deliver_log[0], 32'h0000_0000);
        checkValue("wrap_count", 32'(w_log.size() >= 3), 32'(1));
        checkValue("wrap_pc0", w_log[0], 32'hFFFF_FFF8);
        checkValue("wrap_pc1", w_log[1], 32'hFFFF_FFFC);
        checkValue("wrap_pc2", w_log[2], 32'h0000_0000);

        // Decode stalls long enough for the buffer to fill and requests to stop.
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 100, 100);
        checkValue("stall_req", 32'(req), 32'(0));
        checkValue("stall_valid", 32'(valid), 32'(1));
        checkValue("stall_pc_held", pc, exp_pc);
        start_n = deliver_log.size();
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 100, 100);
        checkValue("post_stall_flow", 32'(deliver_log.size() >= start_n + 3), 32'(1));

        // Redirect with two requests in flight.
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 0, 100);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 100, 0);
        checkValue("two_outst", 32'(pend_q.size()), 32'(2));
        gi = grant_log.size();
        di = deliver_log.size();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0103, 100, 0);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 100, 100);
        checkValue("redir_grant_seen", 32'(grant_log.size() > gi), 32'(1));
        checkValue("redir_addr", grant_log[gi], 32'h0000_0100);
        checkValue("redir_deliver_seen", 32'(deliver_log.size() > di), 32'(1));
        checkValue("redir_first_pc", deliver_log[di], 32'h0000_0100);

        // Redirect coinciding with rvalid and stall.
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (pend_q.size() > 0 && valid) begin
                found = 1'b1;
                break;
            end
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 100, 100);
        end
        checkValue("redir_setup", 32'(found), 32'(1));
        redir_cyc = cyc;
        gi = grant_log.size();
        di = deliver_log.size();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200, 100, 100);
        checkValue("redir_valid_next", 32'(valid), 32'(0));
        checkValue("redir_pc_next", pc, 32'h0);
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 100, 100);
        checkValue("redir_req_delay", 32'(req_after_redir - redir_cyc), 32'(1));
        checkValue("redir2_addr", grant_log[gi], 32'h0000_0200);
        checkValue("redir2_first_pc", deliver_log[di], 32'h0000_0200);

        // Random traffic with a reset in the middle.
        start_n = deliver_log.size();
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000 || i == 5001) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
            end else begin
                rd  = (int'($urandom_range(99)) < 3);
                tgt = $urandom;
                if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                applyStimulus(1'b1, int'($urandom_range(99)) < 30, rd, tgt, 70, 60);
            end
        end
        checkValue("random_progress", 32'(deliver_log.size() - start_n >= 500), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
